// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: single-outstanding imem requests, prefetch FIFO, show-ahead IF/ID outputs.
// Optional performance counters are enabled by defining IF_FETCH_PERF_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];

  logic push;
  logic pop;
  logic ack_drop;

  always_comb begin
    push     = (state == WAIT) && imem_ack && !branch_taken;
    pop      = valid_out && !freeze && !branch_taken;
    ack_drop = imem_ack && ((state == DROP) || ((state == WAIT) && branch_taken));
  end

  always_comb begin
    valid_out       = (count != '0);
    pc_out          = valid_out ? pc_mem[rd_ptr]  : '0;
    instruction_out = valid_out ? ins_mem[rd_ptr] : '0;
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= fetch_pc + 32'd4;
      ins_mem[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (branch_taken) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        fetch_pc <= branch_addr;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + PW'(1);
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        unique case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end

      // Issue only from IDLE, so count alone bounds occupancy plus the outstanding request.
      unique case (state)
        IDLE: begin
          if (!branch_taken && (count < CW'(DEPTH))) begin
            state     <= WAIT;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end else if (branch_taken) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      if (push) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      perf_dropped <= perf_dropped
                    + (branch_taken ? 32'(count) : 32'd0)
                    + (ack_drop ? 32'd1 : 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a latency-programmable instruction memory model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  if_fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .freeze(freeze),
    .branch_taken(branch_taken),
    .branch_addr(branch_addr),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .valid_out(valid_out),
    .pc_out(pc_out),
    .instruction_out(instruction_out)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_dropped(perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 0;
  int wait_cnt = 0;
  int ack_cnt  = 0;
  bit mem_auto = 1'b1;
  bit prev_req = 1'b0;
  logic [31:0] req_log[$];
  logic [31:0] pc_log[$];
  logic [31:0] ins_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hxxxx_xxxx;
  endfunction

  // Logs the current cycle, advances one clock, then the memory decides this cycle's ack.
  task automatic tick();
    if (imem_req && !prev_req) req_log.push_back(imem_addr);
    prev_req = imem_req;
    if (rst && valid_out && !freeze && !branch_taken) begin
      pc_log.push_back(pc_out);
      ins_log.push_back(instruction_out);
    end
    if (imem_ack) ack_cnt++;
    @(posedge clk);
    #1;
    if (mem_auto) begin
      if (imem_req) begin
        if (wait_cnt == lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wait_cnt   = 0;
        end else begin
          imem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    freeze = 1'b0;
    branch_taken = 1'b0;
    imem_ack = 1'b0;
    mem_auto = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    req_log.delete();
    pc_log.delete();
    ins_log.delete();
    ack_cnt = 0;
    wait_cnt = 0;
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 20 && !imem_req; i++) tick();
    n_checks++;
    if (imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_req_timeout: imem_req=%b required 1", name, imem_req);
    end
  endtask

  task automatic wait_pops(input string name, input int n, input int budget);
    for (int i = 0; i < budget && pc_log.size() < n; i++) tick();
    n_checks++;
    if (pc_log.size() < n) begin
      n_fail++;
      $display("FAIL %s_pop_timeout: pops=%0d required %0d", name, pc_log.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid_out); end
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", pc_out); end
    n_checks++; if (instruction_out !== 32'h0) begin n_fail++; $display("FAIL rst_ins: got %h want 0", instruction_out); end
  endtask

  task automatic test_sequential();
    do_reset();
    lat = 1;
    wait_pops("seq", 4, 40);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (qget(req_log, i) !== 32'(4 * i)) begin
        n_fail++; $display("FAIL seq_addr[%0d]: got %h want %h", i, qget(req_log, i), 32'(4 * i));
      end
      n_checks++;
      if (qget(pc_log, i) !== 32'(4 * (i + 1))) begin
        n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, qget(pc_log, i), 32'(4 * (i + 1)));
      end
      n_checks++;
      if (qget(ins_log, i) !== mem_word(32'(4 * i))) begin
        n_fail++; $display("FAIL seq_ins[%0d]: got %h want %h", i, qget(ins_log, i), mem_word(32'(4 * i)));
      end
    end
  endtask

  task automatic test_freeze();
    int bad;
    do_reset();
    lat = 0;
    freeze = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid_out && pc_out !== 32'h4) bad++;
    end
    n_checks++; if (ack_cnt !== 2) begin n_fail++; $display("FAIL frz_pushes: got %0d want 2", ack_cnt); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL frz_req: got %b want 0", imem_req); end
    n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL frz_valid: got %b want 1", valid_out); end
    n_checks++; if (pc_out !== 32'h4) begin n_fail++; $display("FAIL frz_pc: got %h want 4", pc_out); end
    n_checks++; if (instruction_out !== mem_word(32'h0)) begin n_fail++; $display("FAIL frz_ins: got %h want %h", instruction_out, mem_word(32'h0)); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL frz_pc_hold: got %0d changes want 0", bad); end
    freeze = 1'b0;
    wait_pops("frz", 2, 20);
    n_checks++; if (qget(pc_log, 0) !== 32'h4) begin n_fail++; $display("FAIL frz_drain0: got %h want 4", qget(pc_log, 0)); end
    n_checks++; if (qget(pc_log, 1) !== 32'h8) begin n_fail++; $display("FAIL frz_drain1: got %h want 8", qget(pc_log, 1)); end
    n_checks++; if (qget(ins_log, 1) !== mem_word(32'h4)) begin n_fail++; $display("FAIL frz_drain_ins: got %h want %h", qget(ins_log, 1), mem_word(32'h4)); end
  endtask

  task automatic test_branch_wait();
    do_reset();
    lat = 3;
    wait_req("bw");
    branch_addr = 32'h100;
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL bw_valid: got %b want 0", valid_out); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL bw_hold: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
    wait_pops("bw", 1, 30);
    n_checks++; if (qget(req_log, 1) !== 32'h100) begin n_fail++; $display("FAIL bw_next_addr: got %h want 100", qget(req_log, 1)); end
    n_checks++; if (qget(pc_log, 0) !== 32'h104) begin n_fail++; $display("FAIL bw_first_pc: got %h want 104", qget(pc_log, 0)); end
    n_checks++; if (qget(ins_log, 0) !== mem_word(32'h100)) begin n_fail++; $display("FAIL bw_first_ins: got %h want %h", qget(ins_log, 0), mem_word(32'h100)); end
  endtask

  task automatic test_branch_ack();
    bit found;
    int n_pre;
    do_reset();
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (imem_ack && imem_req && imem_addr === 32'h8) found = 1'b1;
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL ba_ack8_timeout: got %b want 1", found); end
    branch_addr = 32'h300;
    branch_taken = 1'b1;
    n_pre = pc_log.size();
    tick();
    branch_taken = 1'b0;
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL ba_valid: got %b want 0", valid_out); end
    wait_pops("ba", n_pre + 1, 30);
    n_checks++; if (qget(req_log, 3) !== 32'h300) begin n_fail++; $display("FAIL ba_next_addr: got %h want 300", qget(req_log, 3)); end
    n_checks++; if (qget(pc_log, n_pre) !== 32'h304) begin n_fail++; $display("FAIL ba_first_pc: got %h want 304", qget(pc_log, n_pre)); end
    n_checks++; if (qget(ins_log, n_pre) !== mem_word(32'h300)) begin n_fail++; $display("FAIL ba_first_ins: got %h want %h", qget(ins_log, n_pre), mem_word(32'h300)); end
  endtask

  task automatic test_branch_drop();
    int hits;
    do_reset();
    lat = 3;
    wait_req("bd");
    branch_addr = 32'h100;
    branch_taken = 1'b1;
    tick();
    branch_addr = 32'h200;
    tick();
    branch_taken = 1'b0;
    wait_pops("bd", 1, 30);
    hits = 0;
    foreach (req_log[i]) if (req_log[i] === 32'h100) hits++;
    n_checks++; if (hits !== 0) begin n_fail++; $display("FAIL bd_no_100: got %0d requests want 0", hits); end
    n_checks++; if (qget(req_log, 1) !== 32'h200) begin n_fail++; $display("FAIL bd_next_addr: got %h want 200", qget(req_log, 1)); end
    n_checks++; if (qget(pc_log, 0) !== 32'h204) begin n_fail++; $display("FAIL bd_first_pc: got %h want 204", qget(pc_log, 0)); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    lat = 3;
    wait_req("rw");
    tick();
    mem_auto = 1'b0;
    imem_ack = 1'b0;
    rst = 1'b0;
    tick();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rw_req: got %b want 0", imem_req); end
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rw_valid: got %b want 0", valid_out); end
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_ack = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rw_first_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr); end
    tick();
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rw_late_ack: got valid=%b want 0", valid_out); end
`ifdef IF_FETCH_PERF_EN
    n_checks++; if (perf_fetched !== 32'h0) begin n_fail++; $display("FAIL rw_perf_fetched: got %0d want 0", perf_fetched); end
    n_checks++; if (perf_dropped !== 32'h0) begin n_fail++; $display("FAIL rw_perf_dropped: got %0d want 0", perf_dropped); end
`endif
    mem_auto = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_freeze();
    test_branch_wait();
    test_branch_ack();
    test_branch_drop();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
